// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibits the bus, issues a request-to-send,
// shifts a byte plus odd parity on device clock edges and reports ACK, NACK or timeout.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int RTS_CYCLES     = 50,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error,
  output logic       busy,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int MAX_A   = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
  localparam int MAX_CYC = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] RTS_LAST = CNT_W'(RTS_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    SEND,
    ACK,
    WAIT_IDLE
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [3:0]       bit_q;
  logic [7:0]       byte_q;
  logic             parity_q;
  logic [1:0]       clk_sync_q;
  logic [1:0]       data_sync_q;
  logic             clk_prev_q;
  logic             clk_oe_q;
  logic             data_oe_q;
  logic             done_q;
  logic             error_q;
  logic             busy_q;
  logic             ready_q;
  logic             fall_d;
  logic             timeout_d;

  assign cnt_d     = cnt_q + CNT_W'(1);
  assign fall_d    = clk_prev_q & ~clk_sync_q[1];
  assign timeout_d = (cnt_q == TO_LAST);

  always_ff @(posedge clock) begin
    clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
    data_sync_q <= {data_sync_q[0], ps2_data_i};
    clk_prev_q  <= clk_sync_q[1];
    done_q      <= 1'b0;
    error_q     <= 1'b0;
    if (reset) begin
      state_q     <= IDLE;
      clk_oe_q    <= 1'b0;
      data_oe_q   <= 1'b0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b1;
      cnt_q       <= '0;
      bit_q       <= '0;
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_prev_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          clk_oe_q  <= 1'b0;
          data_oe_q <= 1'b0;
          if (tx_valid && ready_q) begin
            byte_q   <= tx_data;
            parity_q <= ~^tx_data;
            cnt_q    <= '0;
            clk_oe_q <= 1'b1;
            busy_q   <= 1'b1;
            ready_q  <= 1'b0;
            state_q  <= INHIBIT;
          end
        end
        INHIBIT: begin
          if (cnt_q == INH_LAST) begin
            cnt_q     <= '0;
            data_oe_q <= 1'b1;
            state_q   <= RTS;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        RTS: begin
          // Start bit stays driven low once the clock line is released.
          if (cnt_q == RTS_LAST) begin
            cnt_q    <= '0;
            bit_q    <= '0;
            clk_oe_q <= 1'b0;
            state_q  <= SEND;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        SEND, ACK, WAIT_IDLE: begin
          cnt_q <= cnt_d;
          if (timeout_d) begin
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            error_q   <= 1'b1;
            busy_q    <= 1'b0;
            ready_q   <= 1'b1;
            state_q   <= IDLE;
          end else if (state_q == SEND) begin
            if (fall_d) begin
              bit_q <= bit_q + 4'd1;
              if (bit_q < 4'd8) begin
                data_oe_q <= ~byte_q[bit_q[2:0]];
              end else if (bit_q == 4'd8) begin
                data_oe_q <= ~parity_q;
              end else begin
                data_oe_q <= 1'b0;
                state_q   <= ACK;
              end
            end
          end else if (state_q == ACK) begin
            if (fall_d) begin
              if (!data_sync_q[1]) begin
                state_q <= WAIT_IDLE;
              end else begin
                error_q <= 1'b1;
                busy_q  <= 1'b0;
                ready_q <= 1'b1;
                state_q <= IDLE;
              end
            end
          end else if (clk_sync_q[1] && data_sync_q[1]) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: begin
          clk_oe_q  <= 1'b0;
          data_oe_q <= 1'b0;
          busy_q    <= 1'b0;
          ready_q   <= 1'b1;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign tx_ready    = ready_q;
  assign tx_done     = done_q;
  assign tx_error    = error_q;
  assign busy        = busy_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx: an open-drain bus with a behavioural PS/2 device model,
// expected outcomes queued at issue time and checked by an independent monitor.
module tb_ps2_host_tx;

  localparam int INH = 20;
  localparam int RTS = 4;
  localparam int TO  = 2000;
  localparam int M_ACK    = 0;
  localparam int M_NACK   = 1;
  localparam int M_SILENT = 2;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, tx_done, tx_error, busy;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       dev_clk_low, dev_data_low;
  logic       line_clk, line_data;

  assign line_clk  = ~(ps2_clk_oe | dev_clk_low);
  assign line_data = ~(ps2_data_oe | dev_data_low);

  always #5 clock = ~clock;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .RTS_CYCLES(RTS), .TIMEOUT_CYCLES(TO)) dut (
    .clock      (clock),
    .reset      (reset),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_done    (tx_done),
    .tx_error   (tx_error),
    .busy       (busy),
    .ps2_clk_i  (line_clk),
    .ps2_data_i (line_data),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  typedef struct packed {
    logic        done;
    logic        has_frame;
    logic [10:0] frame;
  } exp_t;

  exp_t        exp_q[$];
  logic [10:0] dev_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          done_cnt = 0;
  int          err_cnt = 0;
  int          dev_mode = M_ACK;
  bit          dev_active = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Frame as seen on the wire: start, 8 data bits LSB first, odd parity, stop.
  function automatic logic [10:0] ref_frame(input logic [7:0] b);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return {1'b1, (ones % 2 == 0), b, 1'b0};
  endfunction

  task automatic push_exp(input logic [7:0] b, input int mode);
    exp_t e;
    e.done      = (mode == M_ACK);
    e.has_frame = (mode != M_SILENT);
    e.frame     = ref_frame(b);
    exp_q.push_back(e);
  endtask

  // Device model: answers a request-to-send with 11 clock periods of 40 cycles.
  initial begin : device
    logic [10:0] fr;
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
    forever begin
      @(negedge clock);
      if (ps2_clk_oe === 1'b1) begin
        while (ps2_clk_oe === 1'b1) @(negedge clock);
        if (line_data == 1'b0 && dev_mode != M_SILENT) begin
          dev_active = 1'b1;
          for (int i = 0; i < 11; i++) begin
            repeat (20) @(negedge clock);
            fr[i] = line_data;
            if (i == 10) begin
              dev_q.push_back(fr);
              if (dev_mode == M_ACK) dev_data_low = 1'b1;
            end
            dev_clk_low = 1'b1;
            repeat (20) @(negedge clock);
            dev_clk_low = 1'b0;
          end
          dev_data_low = 1'b0;
          dev_active   = 1'b0;
        end
      end
    end
  end

  // Monitor: every done/error pulse consumes one queued expectation.
  always @(negedge clock) begin : monitor
    exp_t e;
    if (tx_done === 1'b1) done_cnt++;
    if (tx_error === 1'b1) err_cnt++;
    if (tx_done === 1'b1 || tx_error === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_pulse: got done=%0b error=%0b, required no pulse", tx_done, tx_error);
      end else begin
        e = exp_q.pop_front();
        check("outcome_done", tx_done, e.done);
        check("outcome_error", tx_error, !e.done);
        check("lines_released", {ps2_clk_oe, ps2_data_oe}, 2'b00);
        check("ready_at_pulse", {tx_ready, busy}, 2'b10);
        if (e.has_frame) begin
          if (dev_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL frame_missing: got none, required 0x%0h", e.frame);
          end else begin
            check("wire_frame", dev_q.pop_front(), e.frame);
          end
        end
      end
    end
  end

  task automatic check_phases();
    int n;
    int m;
    n = 0;
    m = 0;
    while (ps2_clk_oe && !ps2_data_oe && n < 100) begin n++; @(negedge clock); end
    check("inhibit_cycles", n, INH);
    while (ps2_clk_oe && ps2_data_oe && m < 100) begin m++; @(negedge clock); end
    check("rts_cycles", m, RTS);
    check("clk_released_start_bit", {ps2_clk_oe, ps2_data_oe}, 2'b01);
  endtask

  task automatic issue(input logic [7:0] b, input int mode, input bit push);
    dev_mode = mode;
    if (push) push_exp(b, mode);
    check("ready_before_send", tx_ready, 1);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clock);
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
    check("busy_after_accept", busy, 1);
    check_phases();
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while ((busy || dev_active) && k < 5000) begin k++; @(negedge clock); end
    if (k >= 5000) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_idle_timeout: got busy=%0b, required 0", name, busy);
    end
    repeat (3) @(negedge clock);
    check({name, "_ready"}, {tx_ready, busy}, 2'b10);
  endtask

  initial begin : stim
    int d0;
    int e0;
    int k;
    reset    = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    @(negedge clock);
    check("reset_outputs", {tx_ready, busy, tx_done, tx_error, ps2_clk_oe, ps2_data_oe}, 6'b100000);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Single 0xED with ACK
    d0 = done_cnt;
    issue(8'hED, M_ACK, 1'b1);
    wait_idle("ed");
    check("ed_done_count", done_cnt - d0, 1);

    // Back-to-back 0x00 then 0x01
    d0 = done_cnt;
    issue(8'h00, M_ACK, 1'b1);
    k = 0;
    while (!tx_done && k < 3000) begin k++; @(negedge clock); end
    check("b2b_first_done", tx_done, 1);
    check("b2b_ready_on_done", tx_ready, 1);
    push_exp(8'h01, M_ACK);
    tx_data  = 8'h01;
    tx_valid = 1'b1;
    @(negedge clock);
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
    check("b2b_accepted_next_cycle", {busy, ps2_clk_oe}, 2'b11);
    check_phases();
    wait_idle("b2b");
    check("b2b_done_count", done_cnt - d0, 2);

    // Silent device: timeout measured from clock release
    d0 = done_cnt;
    e0 = err_cnt;
    issue(8'($urandom), M_SILENT, 1'b1);
    k = 0;
    while (!tx_error && k < 3000) begin k++; @(negedge clock); end
    check("timeout_latency", k, TO);
    wait_idle("timeout");
    check("timeout_counts", {16'(done_cnt - d0), 16'(err_cnt - e0)}, {16'd0, 16'd1});

    // NACK from device
    e0 = err_cnt;
    issue(8'h3C, M_NACK, 1'b1);
    wait_idle("nack");
    check("nack_error_count", err_cnt - e0, 1);

    // Reset during data bit 4 of 0xFF
    d0 = done_cnt;
    e0 = err_cnt;
    issue(8'hFF, M_ACK, 1'b0);
    repeat (200) @(negedge clock);
    check("busy_before_reset", busy, 1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("reset_mid_transfer", {tx_ready, busy, tx_done, tx_error, ps2_clk_oe, ps2_data_oe}, 6'b100000);
    k = 0;
    while (dev_active && k < 1000) begin k++; @(negedge clock); end
    dev_q.delete();
    repeat (5) @(negedge clock);
    check("reset_no_pulses", (done_cnt - d0) + (err_cnt - e0), 0);
    issue(8'hFF, M_ACK, 1'b1);
    wait_idle("ff_after_reset");
    check("ff_done_count", done_cnt - d0, 1);

    // tx_valid pulsed with 0x55 during an active 0xED transfer
    d0 = done_cnt;
    issue(8'hED, M_ACK, 1'b1);
    repeat (60) @(negedge clock);
    tx_data  = 8'h55;
    tx_valid = 1'b1;
    @(negedge clock);
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
    wait_idle("ignore55");
    repeat (10) @(negedge clock);
    check("ignore55_single_done", {16'(done_cnt - d0), 15'd0, busy}, {16'd1, 16'd0});

    // Randomised bytes with mixed ACK/NACK
    for (int r = 0; r < 6; r++) begin
      issue(8'($urandom), ($urandom_range(0, 3) == 0) ? M_NACK : M_ACK, 1'b1);
      wait_idle("random");
      repeat ($urandom_range(0, 5)) @(negedge clock);
    end

    check("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: got no completion, required finish within 90000 cycles");
    $fatal(1);
  end

endmodule
